serial_frame_rx: RTL and testbench

Oversampled serial frame receiver for the monitor-bus input path. It consumes a line already brought into the `clk` domain by a two-flop synchronizer and sampled at 8 clocks per bit, the same ratio the divide-by-8 bit clock produces. It detects the start bit, samples each bit at mid-cell, assembles a word and presents it with a one-cycle valid strobe. Downstream logic consumes it directly or through the pulse-delay stage.

---
 rtl/serial_frame_rx.sv | 123 ++++++++++++
 tb/tb_serial_frame_rx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// Oversampled (8 clocks/bit) serial frame receiver: start, DATA_BITS MSB-first, stop.
// Define SERIAL_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module serial_frame_rx #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int unsigned CntW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef SERIAL_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StWaitIdle
  } state_e;

  state_e               state_q, state_d;
  logic [2:0]           phase_q;
  logic [CntW-1:0]      bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS:0]   shift_ext;
  logic                 armed_q;
  logic                 mid, start_chk, last_bit, par_bad;
  logic                 valid_d, err_d;

  assign mid       = (phase_q == 3'd7);
  assign start_chk = (phase_q == 3'd3);
  assign last_bit  = (bit_cnt_q == CntW'(DATA_BITS - 1));
  assign shift_ext = {shift_q, rx_in};

`ifdef SERIAL_RX_PARITY_EN
  logic par_acc_q, par_bad_q;
  assign par_bad = par_bad_q;
`else
  assign par_bad = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (armed_q && !rx_in) state_d = StStart;
      StStart:    if (start_chk) state_d = rx_in ? StIdle : StData;
`ifdef SERIAL_RX_PARITY_EN
      StData:     if (mid && last_bit) state_d = StParity;
      StParity:   if (mid) state_d = StStop;
`else
      StData:     if (mid && last_bit) state_d = StStop;
`endif
      // A bad parity with a good stop bit needs no break absorption.
      StStop:     if (mid) state_d = rx_in ? StIdle : StWaitIdle;
      StWaitIdle: if (rx_in) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    busy    = (state_q != StIdle);
    valid_d = (state_q == StStop) && mid && rx_in && !par_bad;
    err_d   = (state_q == StStop) && mid && !(rx_in && !par_bad);
  end

  // Datapath and registered strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q     <= 3'd0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      armed_q     <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      armed_q     <= armed_q | rx_in;
      data_valid  <= valid_d;
      frame_error <= err_d;
      if (valid_d) data_out <= shift_q;

      if (state_q == StIdle || (state_q == StStart && start_chk)) phase_q <= 3'd0;
      else                                                       phase_q <= phase_q + 3'd1;

      if (state_q != StData) bit_cnt_q <= '0;
      else if (mid)          bit_cnt_q <= bit_cnt_q + CntW'(1);

      if (state_q == StData && mid) shift_q <= shift_ext[DATA_BITS-1:0];
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_acc_q <= 1'b0;
      par_bad_q <= 1'b0;
    end else if (state_q == StStart) begin
      par_acc_q <= 1'b0;
      par_bad_q <= 1'b0;
    end else if (state_q == StData && mid) begin
      par_acc_q <= par_acc_q ^ rx_in;
    end else if (state_q == StParity && mid) begin
      par_bad_q <= par_acc_q ^ rx_in;
    end
  end
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: the driver queues expected strobes, a monitor checks them.
// A value registered at posedge n is reported as cycle n+1, matching the E+77 convention.
module tb_serial_frame_rx;

`ifdef SERIAL_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int LAT = 77 + 8 * PAR;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_in = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, frame_error, busy;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       q[$];
  exp_t       mon_x;
  logic [7:0] model_out = 8'h00;
  bit         mon_en = 1'b0;

  serial_frame_rx #(.DATA_BITS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame starting at a negedge; rst_at > 0 pulses reset at edge E+rst_at.
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit par_flip,
                            input int rst_at);
    logic bits [11];
    int   nb;
    int   e;
    bit   good;
    exp_t x;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[7-i];
    nb = 9;
    if (PAR != 0) begin
      bits[nb] = (^d) ^ par_flip;
      nb++;
    end
    bits[nb] = stop;
    nb++;
    e = cyc + 1;
    if (rst_at == 0) begin
      good     = stop && !(par_flip && PAR != 0);
      x.is_err = !good;
      x.data   = good ? d : model_out;
      x.cyc    = e + LAT;
      q.push_back(x);
      if (good) model_out = d;
    end
    for (int i = 0; i < nb * 8; i++) begin
      rx_in = bits[i/8];
      reset = (rst_at != 0) && (cyc + 1 == e + rst_at);
      @(negedge clk);
    end
    reset = 1'b0;
    if (rst_at != 0) model_out = 8'h00;
  endtask

  always @(negedge clk) begin
    if (mon_en && (data_valid || frame_error)) begin
      check("strobe_exclusive", {31'd0, data_valid & frame_error}, 32'd0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got valid=%0b err=%0b expected none (cycle %0d)",
                 data_valid, frame_error, cyc + 1);
      end else begin
        mon_x = q.pop_front();
        check("strobe_kind_err", {31'd0, frame_error}, {31'd0, mon_x.is_err});
        check("data_out", {24'd0, data_out}, {24'd0, mon_x.data});
        check("strobe_cycle", cyc + 1, mon_x.cyc);
      end
    end
  end

  initial begin
    int e;
    repeat (2) @(negedge clk);
    check("rst_data_out", {24'd0, data_out}, 32'd0);
    check("rst_data_valid", {31'd0, data_valid}, 32'd0);
    check("rst_frame_error", {31'd0, frame_error}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Line stuck low after reset: never armed
    rx_in = 1'b0;
    repeat (20) @(negedge clk);
    check("stuck_low_busy", {31'd0, busy}, 32'd0);
    idle(20);

    send_frame(8'hA5, 1'b1, 1'b0, 0);
    idle(10);

    // Two-clock start glitch
    e = cyc + 1;
    rx_in = 1'b0;
    @(negedge clk);
    check("glitch_busy_e1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    check("glitch_busy_e5", {31'd0, busy}, 32'd0);
    check("glitch_time", cyc + 1, e + 5);
    idle(10);
    send_frame(8'h3C, 1'b1, 1'b0, 0);
    idle(5);

    // Framing error followed by a break
    send_frame(8'h5A, 1'b0, 1'b0, 0);
    rx_in = 1'b0;
    repeat (40) @(negedge clk);
    check("break_busy", {31'd0, busy}, 32'd1);
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    check("break_release_busy", {31'd0, busy}, 32'd0);
    idle(10);

    // Reset mid-frame
    send_frame(8'hFF, 1'b1, 1'b0, 30);
    idle(10);
    check("mid_reset_data_out", {24'd0, data_out}, 32'd0);
    send_frame(8'h81, 1'b1, 1'b0, 0);
    idle(5);

    // Back-to-back frames
    send_frame(8'h01, 1'b1, 1'b0, 0);
    send_frame(8'hFE, 1'b1, 1'b0, 0);

`ifdef SERIAL_RX_PARITY_EN
    idle(5);
    send_frame(8'h07, 1'b1, 1'b0, 0);
    idle(5);
    send_frame(8'h07, 1'b1, 1'b1, 0);
`endif
    idle(5);

    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    check("queue_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
